// File: rtl/axi4s_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axi4s_rr_arbiter
//  Description : Packet-level round-robin arbiter that shares one AXI4-Stream
//                master port between NUM_SRC slave ports. The grant is held
//                from arbitration until the granted source's tlast beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4s_rr_arbiter #(
  parameter int NUM_SRC      = 4,
  parameter int TDATA_WIDTH  = 32,
  parameter int TUSER_WIDTH  = 4,
  parameter int SRC_ID_WIDTH = 3
) (
  input  logic                              axi4s_aclk,
  input  logic                              axi4s_areset,
  input  logic [NUM_SRC-1:0]                s_axis_tvalid,
  output logic [NUM_SRC-1:0]                s_axis_tready,
  input  logic [NUM_SRC*TDATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [NUM_SRC*(TDATA_WIDTH/8)-1:0] s_axis_tkeep,
  input  logic [NUM_SRC-1:0]                s_axis_tlast,
  input  logic [NUM_SRC*TUSER_WIDTH-1:0]    s_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [TDATA_WIDTH-1:0]            m_axis_tdata,
  output logic [TDATA_WIDTH/8-1:0]          m_axis_tkeep,
  output logic                              m_axis_tlast,
  output logic [TUSER_WIDTH-1:0]            m_axis_tuser,
  output logic [SRC_ID_WIDTH-1:0]           m_axis_tid,
  output logic                              grant_valid,
  output logic [SRC_ID_WIDTH-1:0]           grant_id,
  output logic                              pkt_done
);

  localparam int KEEP_WIDTH = TDATA_WIDTH / 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t                  state_q;
  logic [SRC_ID_WIDTH-1:0] grant_id_q;
  logic [SRC_ID_WIDTH-1:0] last_grant_q;
  logic                    pkt_done_q;

  logic                    arb_found;
  logic [SRC_ID_WIDTH-1:0] arb_idx;
  logic                    last_beat;

  // Round-robin search: first requester at last_grant+1, +2, ... modulo NUM_SRC
  always_comb begin
    int cand;
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = int'(last_grant_q) + k;
      if (cand >= NUM_SRC) begin
        cand = cand - NUM_SRC;
      end
      if (!arb_found && s_axis_tvalid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = SRC_ID_WIDTH'(cand);
      end
    end
  end

  // Combinational pass-through of the granted source; everything low when idle
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = '0;
    s_axis_tready = '0;
    if (state_q == ST_XFER) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (grant_id_q == SRC_ID_WIDTH'(i)) begin
          m_axis_tvalid    = s_axis_tvalid[i];
          m_axis_tdata     = s_axis_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
          m_axis_tkeep     = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
          m_axis_tlast     = s_axis_tlast[i];
          m_axis_tuser     = s_axis_tuser[i*TUSER_WIDTH +: TUSER_WIDTH];
          s_axis_tready[i] = m_axis_tready;
        end
      end
    end
  end

  assign last_beat   = m_axis_tvalid & m_axis_tready & m_axis_tlast;
  assign m_axis_tid  = (state_q == ST_XFER) ? grant_id_q : '0;
  assign grant_valid = (state_q == ST_XFER);
  assign grant_id    = grant_id_q;
  assign pkt_done    = pkt_done_q;

  // Grant FSM: lock onto a source at arbitration, release after its tlast beat
  always_ff @(posedge axi4s_aclk) begin
    if (axi4s_areset) begin
      state_q      <= ST_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= SRC_ID_WIDTH'(NUM_SRC - 1);
      pkt_done_q   <= 1'b0;
    end else begin
      pkt_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_found) begin
            grant_id_q <= arb_idx;
            state_q    <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (last_beat) begin
            state_q      <= ST_IDLE;
            last_grant_q <= grant_id_q;
            pkt_done_q   <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi4s_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi4s_rr_arbiter
//  Description : Self-checking bench for axi4s_rr_arbiter. Sources are driven
//                from per-source beat queues; a packet-level reference model
//                predicts grant, pass-through and completion behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4s_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int UW = 4;
  localparam int IW = 3;
  localparam int KW = DW / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    s_tvalid, s_tready, s_tlast;
  logic [N*DW-1:0] s_tdata;
  logic [N*KW-1:0] s_tkeep;
  logic [N*UW-1:0] s_tuser;
  logic            m_tvalid, m_tready, m_tlast;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic [UW-1:0]   m_tuser;
  logic [IW-1:0]   m_tid, grant_id;
  logic            grant_valid, pkt_done;

  always #5 clk = ~clk;

  axi4s_rr_arbiter #(
    .NUM_SRC(N), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .SRC_ID_WIDTH(IW)
  ) dut (
    .axi4s_aclk   (clk),
    .axi4s_areset (rst),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tdata (s_tdata),
    .s_axis_tkeep (s_tkeep),
    .s_axis_tlast (s_tlast),
    .s_axis_tuser (s_tuser),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tkeep (m_tkeep),
    .m_axis_tlast (m_tlast),
    .m_axis_tuser (m_tuser),
    .m_axis_tid   (m_tid),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id),
    .pkt_done     (pkt_done)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic [UW-1:0] u;
  } beat_t;

  beat_t srcq[N][$];
  bit    vld[N];
  int    vld_pct = 100;
  int    rdy_pct = 100;
  int    gen_pct = 0;
  bit    rdy_pat[$];
  int    grant_log[$];

  // reference model: who owns the output, who was served last, done pulse due
  bit    mdl_busy;
  int    mdl_owner;
  int    mdl_last;
  bit    mdl_done;

  int    n_cmp = 0;
  int    n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_pkt(input int src, input int len, input int base);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      b.d = (base >= 0) ? DW'(base + j) : DW'($urandom);
      b.k = KW'($urandom);
      b.u = UW'($urandom);
      b.l = (j == len - 1);
      srcq[src].push_back(b);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (!vld[i] && srcq[i].size() > 0 && $urandom_range(0, 99) < vld_pct) vld[i] = 1'b1;
      s_tvalid[i] = vld[i];
      if (vld[i]) begin
        s_tdata[i*DW +: DW] = srcq[i][0].d;
        s_tkeep[i*KW +: KW] = srcq[i][0].k;
        s_tlast[i]          = srcq[i][0].l;
        s_tuser[i*UW +: UW] = srcq[i][0].u;
      end else begin
        s_tdata[i*DW +: DW] = '0;
        s_tkeep[i*KW +: KW] = '0;
        s_tlast[i]          = 1'b0;
        s_tuser[i*UW +: UW] = '0;
      end
    end
    if (rdy_pat.size() > 0) m_tready = rdy_pat.pop_front();
    else                    m_tready = ($urandom_range(0, 99) < rdy_pct);
  endtask

  task automatic model_reset();
    mdl_busy  = 1'b0;
    mdl_owner = 0;
    mdl_last  = N - 1;
    mdl_done  = 1'b0;
    for (int i = 0; i < N; i++) begin
      srcq[i].delete();
      vld[i] = 1'b0;
    end
  endtask

  // one clock cycle: check outputs mid-cycle, advance model, drive next inputs
  task automatic step();
    bit          exp_tv, hs, nb, nd;
    int          ng, nl, idx;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    exp_tv  = mdl_busy && vld[mdl_owner];
    exp_rdy = mdl_busy ? (N'(m_tready) << mdl_owner) : '0;
    chk("grant_valid", grant_valid, mdl_busy);
    chk("pkt_done", pkt_done, mdl_done);
    chk("m_tvalid", m_tvalid, exp_tv);
    chk("s_tready", s_tready, exp_rdy);
    chk("m_tid", m_tid, mdl_busy ? mdl_owner : 0);
    if (mdl_busy) chk("grant_id", grant_id, mdl_owner);
    if (exp_tv) begin
      chk("m_tdata", m_tdata, srcq[mdl_owner][0].d);
      chk("m_tkeep", m_tkeep, srcq[mdl_owner][0].k);
      chk("m_tlast", m_tlast, srcq[mdl_owner][0].l);
      chk("m_tuser", m_tuser, srcq[mdl_owner][0].u);
    end
    hs = exp_tv && m_tready;
    nb = mdl_busy; ng = mdl_owner; nl = mdl_last; nd = 1'b0;
    if (!rst) begin
      if (!mdl_busy) begin
        for (int k = 1; k <= N; k++) begin
          idx = (mdl_last + k) % N;
          if (vld[idx]) begin
            nb = 1'b1; ng = idx;
            grant_log.push_back(idx);
            break;
          end
        end
      end else if (hs && srcq[mdl_owner][0].l) begin
        nb = 1'b0; nl = mdl_owner; nd = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      if (hs) begin
        void'(srcq[mdl_owner].pop_front());
        vld[mdl_owner] = 1'b0;
      end
      mdl_busy = nb; mdl_owner = ng; mdl_last = nl; mdl_done = nd;
      if (gen_pct > 0) begin
        for (int i = 0; i < N; i++)
          if (srcq[i].size() == 0 && $urandom_range(0, 99) < gen_pct)
            push_pkt(i, $urandom_range(1, 6), -1);
      end
    end
    drive_inputs();
  endtask

  task automatic run_until_empty(input int budget);
    int  cyc;
    bit  pending;
    cyc = 0;
    pending = 1'b1;
    while (pending && cyc < budget) begin
      step();
      cyc++;
      pending = mdl_busy || mdl_done;
      for (int i = 0; i < N; i++) if (srcq[i].size() > 0) pending = 1'b1;
    end
    chk("drain_timeout", pending, 1'b0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int c = 0; c < cycles; c++) step();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wait_cyc;
    rst = 1'b1;
    for (int i = 0; i < N; i++) vld[i] = 1'b0;
    drive_inputs();
    @(posedge clk);
    #1;
    model_reset();
    drive_inputs();

    // reset held, then idle with no requests
    do_reset(3);
    for (int c = 0; c < 4; c++) step();

    // single source, src2 4-beat packet
    grant_log.delete();
    push_pkt(2, 4, 'hA0);
    drive_inputs();
    run_until_empty(40);
    chk("single_grant_cnt", grant_log.size(), 1);
    if (grant_log.size() > 0) chk("single_grant_id", grant_log[0], 2);

    // round robin, all sources two 2-beat packets each
    do_reset(1);
    grant_log.delete();
    for (int i = 0; i < N; i++) begin
      push_pkt(i, 2, 16 * i);
      push_pkt(i, 2, 16 * i + 8);
    end
    drive_inputs();
    run_until_empty(100);
    chk("rr_grant_cnt", grant_log.size(), 2 * N);
    for (int j = 0; j < grant_log.size() && j < 2 * N; j++) chk("rr_order", grant_log[j], j % N);

    // backpressure on src1
    do_reset(1);
    rdy_pat.delete();
    rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    push_pkt(1, 3, 'h10);
    drive_inputs();
    run_until_empty(40);

    // grant lock with a late requester
    do_reset(1);
    grant_log.delete();
    push_pkt(0, 5, 'h50);
    drive_inputs();
    wait_cyc = 0;
    while (srcq[0].size() > 3 && wait_cyc < 30) begin step(); wait_cyc++; end
    push_pkt(3, 2, 'h30);
    wait_cyc = 0;
    while (grant_log.size() < 2 && wait_cyc < 30) begin step(); wait_cyc++; end
    push_pkt(1, 2, 'h11);
    run_until_empty(60);
    chk("lock_grant_cnt", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
      chk("lock_order0", grant_log[0], 0);
      chk("lock_order1", grant_log[1], 3);
      chk("lock_order2", grant_log[2], 1);
    end

    // reset in the middle of a src1 packet
    do_reset(1);
    push_pkt(1, 6, 'h60);
    drive_inputs();
    wait_cyc = 0;
    while (srcq[1].size() > 4 && wait_cyc < 30) begin step(); wait_cyc++; end
    do_reset(1);
    grant_log.delete();
    push_pkt(1, 2, 'h70);
    push_pkt(2, 2, 'h80);
    drive_inputs();
    run_until_empty(40);
    chk("rst_abort_cnt", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("rst_abort_first", grant_log[0], 1);
      chk("rst_abort_second", grant_log[1], 2);
    end

    // randomized traffic with random valid and ready
    do_reset(1);
    vld_pct = 70;
    rdy_pct = 70;
    gen_pct = 15;
    for (int c = 0; c < 3000; c++) step();
    gen_pct = 0;
    rdy_pct = 100;
    vld_pct = 100;
    run_until_empty(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi4s_rr_arbiter.md
Name: axi4s_rr_arbiter

Overview:
- Packet-level round-robin arbiter. Shares one AXI4-Stream master port between NUM_SRC AXI4-Stream slave ports.
- Grant is locked to one source from arbitration until that source's tlast beat completes. Packets are never interleaved.
- Sits upstream of a single shared stream consumer (DMA, FIFO, debug monitor).
- Exposes grant and packet-completion status for instrumentation.

Parameters:
- NUM_SRC, 4, number of slave (requester) ports; legal range 2..8.
- TDATA_WIDTH, 32, tdata width in bits; multiple of 8.
- TUSER_WIDTH, 4, tuser width in bits.
- SRC_ID_WIDTH, 3, width of the grant/id outputs; must satisfy 2**SRC_ID_WIDTH >= NUM_SRC.

Ports:
- axi4s_aclk  in  1  single clock; all logic is on the rising edge.
- axi4s_areset  in  1  synchronous, active-high reset.
- s_axis_tvalid  in  NUM_SRC  per-source tvalid; bit i = source i.
- s_axis_tready  out  NUM_SRC  per-source tready.
- s_axis_tdata  in  NUM_SRC*TDATA_WIDTH  flattened; source i occupies bits [i*TDATA_WIDTH +: TDATA_WIDTH].
- s_axis_tkeep  in  NUM_SRC*(TDATA_WIDTH/8)  flattened, same packing.
- s_axis_tlast  in  NUM_SRC  per-source tlast.
- s_axis_tuser  in  NUM_SRC*TUSER_WIDTH  flattened, same packing.
- m_axis_tvalid  out  1  shared output tvalid.
- m_axis_tready  in  1  shared output tready.
- m_axis_tdata  out  TDATA_WIDTH  shared output tdata.
- m_axis_tkeep  out  TDATA_WIDTH/8  shared output tkeep.
- m_axis_tlast  out  1  shared output tlast.
- m_axis_tuser  out  TUSER_WIDTH  shared output tuser.
- m_axis_tid  out  SRC_ID_WIDTH  index of the granted source, valid with m_axis_tvalid.
- grant_valid  out  1  high while a source holds the grant (state XFER).
- grant_id  out  SRC_ID_WIDTH  registered index of the granted source.
- pkt_done  out  1  one-cycle pulse, the cycle after a tlast beat handshakes.

Behaviour:
- Reset (axi4s_areset=1 at a clock edge):
  - state=IDLE, grant_valid=0, grant_id=0, pkt_done=0.
  - last_grant=NUM_SRC-1, so source 0 has top priority after reset.
  - All s_axis_tready=0, m_axis_tvalid=0.
- Reset mid-packet: the packet is abandoned. No tlast is synthesized, and the next packet on the output starts from a fresh arbitration.
- State IDLE:
  - If any s_axis_tvalid bit is high, select the first requesting index searching last_grant+1, last_grant+2, ... modulo NUM_SRC.
  - Register that index into grant_id, set grant_valid=1, go to XFER.
  - Arbitration latency is 1 cycle: the first beat can transfer in the cycle after the request is sampled.
  - If no bit is high, stay in IDLE.
  - In IDLE all outputs that depend on the grant are forced low.
- State XFER, with g = grant_id:
  - Output path is combinational: m_axis_tvalid = s_axis_tvalid[g]; m_axis_tdata/tkeep/tlast/tuser = source g's fields; m_axis_tid = g.
  - s_axis_tready[g] = m_axis_tready; every other s_axis_tready bit = 0.
  - The tvalid/tready handshake passes straight through with no added latency and no buffering.
  - On a beat where m_axis_tvalid & m_axis_tready & m_axis_tlast:
    - next state IDLE, last_grant <= g, grant_valid <= 0.
    - pkt_done pulses high on the following cycle.
- Inter-packet gap: there is at least one IDLE cycle between packets, so maximum throughput is N beats per N+1 cycles.
- Grant lock rules:
  - The grant is never revoked while in XFER.
  - If the granted source drops tvalid mid-packet, the arbiter waits indefinitely.
  - Other requesters that assert in the meantime are ignored until the tlast beat.
- Fairness: with all sources continuously requesting, grants rotate 0,1,2,...,NUM_SRC-1,0. No source waits more than NUM_SRC-1 packets.
- Single requester: it is re-granted after each one-cycle IDLE gap.
- tvalid low while granted: when source g deasserts tvalid in XFER, m_axis_tvalid=0 and no transfer occurs.
- Source index wrap: last_grant=NUM_SRC-1 wraps the search to index 0. Unused id codes (index >= NUM_SRC) are never generated.
- pkt_done and grant_id are registered outputs. All m_axis_* outputs are combinational from the registered grant.

Test Plan:
- Reset then idle: hold axi4s_areset high 3 cycles, no tvalid -> grant_valid=0, m_axis_tvalid=0, s_axis_tready=0000, pkt_done never pulses.
- Single source: src2 sends a 4-beat packet (tdata 0xA0..0xA3, tlast on beat 4), m_axis_tready=1 -> grant_id=2 one cycle after request, 4 beats on m_axis with m_axis_tid=2, pkt_done pulse one cycle after beat 4, then IDLE.
- Round robin: all 4 sources request continuously with 2-beat packets -> grant order 0,1,2,3,0,1; each packet emitted intact; one IDLE cycle between packets.
- Backpressure: src1 granted; m_axis_tready toggles 1,0,0,1,1 over a 3-beat packet -> beats transfer only on tready=1 cycles; s_axis_tready[1] mirrors m_axis_tready; src0 and src3 tready stay 0.
- Lock with late requester: src0 mid-packet (beat 2 of 5), src3 asserts tvalid -> src0 completes all 5 beats uninterrupted; src3 granted next even though src1 requests after src3.
- Reset mid-packet: assert axi4s_areset during beat 3 of a 6-beat src1 packet -> next cycle grant_valid=0 and all tready=0; after release with src1 and src2 both requesting, src0 priority applies, so src1 wins; no pkt_done pulse for the aborted packet.
